// File: rtl/evcap_pkg.sv
// ---------------------------------------------------------------------------
// evcap_pkg
//  Shared definitions for the 8-channel event capture stage.
//  Contents:
//   N_CH        channel count (fixed at 8, matches the downstream 8-input OR)
//   CNT_W_DEF   default width of the saturating capture counter
//   FILT_CYC    stable cycles the glitch filter needs before its output moves
//   FILT_CNT_W  width of the per-channel filter counter and the ARM extension
//   evcap_state_e  arming FSM states (ARM0, ARM1, ARM2, RUN)
//   popcount()  number of set bits in a channel vector
//  Optional feature macro: EVCAP_FILTER_EN (filter build; see evcap_filter).
// ---------------------------------------------------------------------------
package evcap_pkg;

    localparam int N_CH       = 8;
    localparam int CNT_W_DEF  = 8;
    localparam int FILT_CYC   = 4;
    localparam int FILT_CNT_W = 4;

    typedef enum logic [1:0] {
        ARM0 = 2'd0,
        ARM1 = 2'd1,
        ARM2 = 2'd2,
        RUN  = 2'd3
    } evcap_state_e;

    // Counts the ones in a channel vector; 4 bits cover 0..8.
    function automatic logic [3:0] popcount(input logic [N_CH-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < N_CH; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/evcap_filter.sv
// ---------------------------------------------------------------------------
// evcap_filter
//  One-channel glitch filter (debouncer) placed after the synchroniser.
//  The filtered level follows din_i only once din_i has differed from it for
//  FILT_CYC consecutive cycles; any cycle where they agree restarts the count.
//  Only present when EVCAP_FILTER_EN is defined.
//  Ports:
//   clk     in  1  clock, rising edge
//   rst     in  1  asynchronous active-high reset (filter state -> 0)
//   din_i   in  1  synchronised level (s2)
//   dout_o  out 1  filtered level
// ---------------------------------------------------------------------------
`ifdef EVCAP_FILTER_EN
module evcap_filter
    import evcap_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic dout_o
);

    logic [FILT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  filt_q, filt_d;

    // The count reaching FILT_CYC-1 means this is the FILT_CYC-th differing
    // cycle, so the output flips at the end of it.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (din_i == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == FILT_CNT_W'(FILT_CYC - 1)) begin
            filt_d = din_i;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + FILT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign dout_o = filt_q;

endmodule
`endif

// File: rtl/event_capture8.sv
// ---------------------------------------------------------------------------
// event_capture8
//  8-channel wake/interrupt event capture stage feeding an 8-input OR.
//  Synchronises raw event lines, detects rising edges once armed, keeps
//  sticky pending/overflow bits and a saturating count of captured edges.
//  Optional feature macro: EVCAP_FILTER_EN adds a per-channel glitch filter
//  after the synchroniser and lengthens the arming window by FILT_CYC cycles.
//  Ports:
//   clk      in  1      clock, rising edge
//   rst      in  1      asynchronous active-high reset
//   ev_in    in  N_CH   raw asynchronous event lines
//   mask_i   in  N_CH   1 = hide channel from evt_o (capture still happens)
//   clr_vld  in  1      clear strobe
//   clr_i    in  N_CH   write-1-to-clear for pend/ovf while clr_vld=1
//   cnt_clr  in  1      synchronous clear of cap_cnt (wins over counting)
//   evt_o    out N_CH   pend & ~mask_i, to the OR stage
//   pend_o   out N_CH   sticky pending bits
//   ovf_o    out N_CH   sticky overflow bits
//   cap_cnt  out CNT_W  saturating captured-edge count
//   armed_o  out 1      FSM has reached RUN
// ---------------------------------------------------------------------------
module event_capture8
    import evcap_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  ev_in,
    input  logic [N_CH-1:0]  mask_i,
    input  logic             clr_vld,
    input  logic [N_CH-1:0]  clr_i,
    input  logic             cnt_clr,
    output logic [N_CH-1:0]  evt_o,
    output logic [N_CH-1:0]  pend_o,
    output logic [N_CH-1:0]  ovf_o,
    output logic [CNT_W-1:0] cap_cnt,
    output logic             armed_o
);

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic [N_CH-1:0]  s1_q, s2_q;
    logic [N_CH-1:0]  lvl;
    logic [N_CH-1:0]  prev_q;
    logic [N_CH-1:0]  pend_q, pend_d;
    logic [N_CH-1:0]  ovf_q, ovf_d;
    logic [N_CH-1:0]  rise;
    logic [N_CH-1:0]  clrMask;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cntSum;
    evcap_state_e     state_q, state_d;

    // Level seen by the edge detector: raw s2, or s2 after the debouncer.
`ifdef EVCAP_FILTER_EN
    for (genvar g = 0; g < N_CH; g++) begin : g_filt
        evcap_filter u_filt (
            .clk    (clk),
            .rst    (rst),
            .din_i  (s2_q[g]),
            .dout_o (lvl[g])
        );
    end
`else
    assign lvl = s2_q;
`endif

    // Arming sequence. Lines already high when reset releases must settle
    // into prev before edges are looked at, otherwise they would read as
    // rising edges. With the filter the extra ARM2 dwell covers the time the
    // filtered level needs to catch up.
`ifdef EVCAP_FILTER_EN
    logic [FILT_CNT_W-1:0] armCnt_q, armCnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armCnt_q <= '0;
        end else begin
            armCnt_q <= armCnt_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
`ifdef EVCAP_FILTER_EN
        armCnt_d = armCnt_q;
`endif
        case (state_q)
            ARM0: state_d = ARM1;
            ARM1: state_d = ARM2;
            ARM2: begin
`ifdef EVCAP_FILTER_EN
                if (armCnt_q == FILT_CNT_W'(FILT_CYC)) begin
                    state_d = RUN;
                end else begin
                    armCnt_d = armCnt_q + FILT_CNT_W'(1);
                end
`else
                state_d = RUN;
`endif
            end
            RUN:     state_d = RUN;
            default: state_d = ARM0;
        endcase
    end

    // Edge detect and sticky bits. A rise always sets pend even when the
    // same bit is being cleared, so no event is lost; in that case the old
    // pend is being retired, so the rise does not count as an overflow.
    always_comb begin
        clrMask = clr_vld ? clr_i : '0;
        rise    = (state_q == RUN) ? (lvl & ~prev_q) : '0;
        pend_d  = (pend_q & ~clrMask) | rise;
        ovf_d   = (ovf_q & ~clrMask) | (rise & pend_q & ~clrMask);
    end

    // Saturating counter; one extra bit on the sum catches the overshoot.
    always_comb begin
        cntSum = {1'b0, cnt_q} + (CNT_W+1)'(popcount(rise));
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cntSum > CNT_MAX) begin
            cnt_d = '1;
        end else begin
            cnt_d = cntSum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
            ovf_q   <= '0;
            cnt_q   <= '0;
            state_q <= ARM0;
        end else begin
            s1_q    <= ev_in;
            s2_q    <= s1_q;
            prev_q  <= lvl;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign evt_o   = pend_q & ~mask_i;
    assign pend_o  = pend_q;
    assign ovf_o   = ovf_q;
    assign cap_cnt = cnt_q;
    assign armed_o = (state_q == RUN);

endmodule

// File: tb/tb_event_capture8.sv
// ---------------------------------------------------------------------------
// tb_event_capture8
//  Directed test of event_capture8. Inputs change on the falling clock edge
//  and outputs are checked there too, half a cycle away from the capture
//  edge. Extra filter latency is folded into FILT_LAT so the same sequence
//  covers both builds (EVCAP_FILTER_EN defined or not).
// ---------------------------------------------------------------------------
module tb_event_capture8;

    import evcap_pkg::*;

`ifdef EVCAP_FILTER_EN
    localparam int FILT_LAT = FILT_CYC;
`else
    localparam int FILT_LAT = 0;
`endif
    // Edges from reset release until armed_o is high.
    localparam int ARM_CYC = 3 + FILT_LAT;
    // Edges from driving ev_in until pend_o shows the event.
    localparam int CAP_LAT = 3 + FILT_LAT;
    // Half-period of the toggle pattern used for bulk counting.
    localparam int PW      = 2 + FILT_LAT;

    logic       clk;
    logic       rst;
    logic [7:0] ev_in;
    logic [7:0] mask_i;
    logic       clr_vld;
    logic [7:0] clr_i;
    logic       cnt_clr;
    logic [7:0] evt_o;
    logic [7:0] pend_o;
    logic [7:0] ovf_o;
    logic [7:0] cap_cnt;
    logic       armed_o;

    int assertCnt;
    int errCnt;

    event_capture8 dut (
        .clk     (clk),
        .rst     (rst),
        .ev_in   (ev_in),
        .mask_i  (mask_i),
        .clr_vld (clr_vld),
        .clr_i   (clr_i),
        .cnt_clr (cnt_clr),
        .evt_o   (evt_o),
        .pend_o  (pend_o),
        .ovf_o   (ovf_o),
        .cap_cnt (cap_cnt),
        .armed_o (armed_o)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n falling edges.
    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive every functional input at once.
    task automatic applyStimulus(input logic [7:0] ev, input logic [7:0] mask,
                                 input logic clrv, input logic [7:0] clr,
                                 input logic cc);
        ev_in   = ev;
        mask_i  = mask;
        clr_vld = clrv;
        clr_i   = clr;
        cnt_clr = cc;
    endtask

    // One comparison: counts it, and reports a failure with tag and values.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCnt++;
        assert (observed === expected)
        else begin
            errCnt++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        assertCnt = 0;
        errCnt    = 0;

        // ---- 1: reset with all lines already high ----
        rst = 1'b1;
        applyStimulus(8'hFF, 8'h00, 1'b0, 8'h00, 1'b0);
        waitCycles(2);
        $display("[TB] reset state");
        checkOutput("rst_pend",  32'(pend_o),  32'h00);
        checkOutput("rst_ovf",   32'(ovf_o),   32'h00);
        checkOutput("rst_evt",   32'(evt_o),   32'h00);
        checkOutput("rst_cnt",   32'(cap_cnt), 32'h00);
        checkOutput("rst_armed", 32'(armed_o), 32'h0);

        rst = 1'b0;
        waitCycles(ARM_CYC - 1);
        checkOutput("arm_not_yet", 32'(armed_o), 32'h0);
        waitCycles(1);
        checkOutput("arm_done", 32'(armed_o), 32'h1);
        waitCycles(10);
        checkOutput("high_at_rst_pend", 32'(pend_o),  32'h00);
        checkOutput("high_at_rst_cnt",  32'(cap_cnt), 32'h00);

        // Falling edges do not capture.
        applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        waitCycles(4 + FILT_LAT);
        checkOutput("fall_ignored", 32'(pend_o), 32'h00);

        // ---- 2: ch3 rise, latency and masking ----
        $display("[TB] ch3 rise");
        applyStimulus(8'h08, 8'h00, 1'b0, 8'h00, 1'b0);
        waitCycles(CAP_LAT - 1);
        checkOutput("ch3_lat_early", 32'(pend_o), 32'h00);
        waitCycles(1);
        checkOutput("ch3_pend", 32'(pend_o),  32'h08);
        checkOutput("ch3_evt",  32'(evt_o),   32'h08);
        checkOutput("ch3_cnt",  32'(cap_cnt), 32'h01);
        mask_i = 8'h08;
        #1;
        checkOutput("mask_evt",  32'(evt_o),   32'h00);
        checkOutput("mask_pend", 32'(pend_o),  32'h08);
        checkOutput("mask_cnt",  32'(cap_cnt), 32'h01);
        mask_i = 8'h00;
        #1;
        checkOutput("unmask_evt", 32'(evt_o), 32'h08);

        // ---- 3: overflow on a second ch3 rise, then clear ----
        waitCycles(1);
        applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        waitCycles(4 + FILT_LAT);
        applyStimulus(8'h08, 8'h00, 1'b0, 8'h00, 1'b0);
        waitCycles(CAP_LAT);
        checkOutput("ovf_set",  32'(ovf_o),   32'h08);
        checkOutput("ovf_pend", 32'(pend_o),  32'h08);
        checkOutput("ovf_cnt",  32'(cap_cnt), 32'h02);
        applyStimulus(8'h08, 8'h00, 1'b1, 8'h08, 1'b0);
        waitCycles(1);
        applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("clr_pend", 32'(pend_o), 32'h00);
        checkOutput("clr_ovf",  32'(ovf_o),  32'h00);

        // ---- 4: clear coinciding with a ch5 rise while pend[5] is set ----
        waitCycles(4 + FILT_LAT);
        applyStimulus(8'h20, 8'h00, 1'b0, 8'h00, 1'b0);
        waitCycles(CAP_LAT);
        checkOutput("ch5_first", 32'(pend_o), 32'h20);
        applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        waitCycles(4 + FILT_LAT);
        applyStimulus(8'h20, 8'h00, 1'b0, 8'h00, 1'b0);
        waitCycles(CAP_LAT - 1);
        applyStimulus(8'h20, 8'h00, 1'b1, 8'h20, 1'b0);
        waitCycles(1);
        applyStimulus(8'h20, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("setwins_pend", 32'(pend_o),  32'h20);
        checkOutput("setwins_ovf",  32'(ovf_o),   32'h00);
        checkOutput("setwins_cnt",  32'(cap_cnt), 32'h04);

        // ---- 5: bulk counting and saturation ----
        $display("[TB] bulk counting");
        applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        waitCycles(4 + FILT_LAT);
        for (int i = 0; i < 10; i++) begin
            ev_in = 8'hFF;
            waitCycles(PW);
            ev_in = 8'h00;
            waitCycles(PW);
        end
        waitCycles(2);
        checkOutput("cnt_84", 32'(cap_cnt), 32'd84);
        for (int i = 0; i < 30; i++) begin
            ev_in = 8'hFF;
            waitCycles(PW);
            ev_in = 8'h00;
            waitCycles(PW);
        end
        waitCycles(2);
        checkOutput("cnt_sat", 32'(cap_cnt), 32'd255);
        checkOutput("all_ovf", 32'(ovf_o),   32'hFF);

        // cnt_clr in the same cycle as a rise: the rise is not counted.
        applyStimulus(8'h01, 8'h00, 1'b0, 8'h00, 1'b0);
        waitCycles(CAP_LAT - 1);
        applyStimulus(8'h01, 8'h00, 1'b0, 8'h00, 1'b1);
        waitCycles(1);
        applyStimulus(8'h01, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("cntclr_zero", 32'(cap_cnt), 32'd0);
        waitCycles(4);
        checkOutput("cntclr_hold", 32'(cap_cnt), 32'd0);
        applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        waitCycles(4 + FILT_LAT);
        applyStimulus(8'h02, 8'h00, 1'b0, 8'h00, 1'b0);
        waitCycles(CAP_LAT);
        checkOutput("cnt_resume", 32'(cap_cnt), 32'd1);

        // ---- mid-operation reset clears asynchronously and re-arms ----
        $display("[TB] mid-run reset");
        rst = 1'b1;
        #1;
        checkOutput("async_pend",  32'(pend_o),  32'h00);
        checkOutput("async_ovf",   32'(ovf_o),   32'h00);
        checkOutput("async_cnt",   32'(cap_cnt), 32'h00);
        checkOutput("async_armed", 32'(armed_o), 32'h0);
        waitCycles(1);
        applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        waitCycles(ARM_CYC - 1);
        checkOutput("rearm_not_yet", 32'(armed_o), 32'h0);
        waitCycles(1);
        checkOutput("rearm_done", 32'(armed_o), 32'h1);
        waitCycles(2);

`ifdef EVCAP_FILTER_EN
        // ---- 6: glitch filter ----
        $display("[TB] glitch filter");
        ev_in = 8'h01;
        waitCycles(3);
        ev_in = 8'h00;
        waitCycles(12);
        checkOutput("glitch_pend", 32'(pend_o),  32'h00);
        checkOutput("glitch_cnt",  32'(cap_cnt), 32'h00);
        ev_in = 8'h01;
        waitCycles(6);
        checkOutput("filt_lat_early", 32'(pend_o), 32'h00);
        ev_in = 8'h00;
        waitCycles(1);
        checkOutput("filt_pend", 32'(pend_o),  32'h01);
        checkOutput("filt_cnt",  32'(cap_cnt), 32'h01);
`else
        // One-cycle pulse driven synchronously is still caught unfiltered.
        $display("[TB] short pulse");
        ev_in = 8'h01;
        waitCycles(1);
        ev_in = 8'h00;
        waitCycles(1);
        checkOutput("pulse_early", 32'(pend_o), 32'h00);
        waitCycles(1);
        checkOutput("pulse_pend", 32'(pend_o),  32'h01);
        checkOutput("pulse_cnt",  32'(cap_cnt), 32'h01);
`endif

        waitCycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, errCnt);
        $finish;
    end

endmodule
